// File: rtl/uart_tx_if.sv
// Byte-producer side of the burst UART transmitter: burst length, payload,
// start request and the serial line coming back.
interface uart_tx_if #(
  parameter int COUNT_W = 10
);
  logic [COUNT_W-1:0] bytes_to_tx;
  logic [7:0]         tx_data_byte;
  logic               tx_data_valid;
  logic               serial_data_out;

  modport master (
    output bytes_to_tx,
    output tx_data_byte,
    output tx_data_valid,
    input  serial_data_out
  );

  modport slave (
    input  bytes_to_tx,
    input  tx_data_byte,
    input  tx_data_valid,
    output serial_data_out
  );
endinterface

// File: rtl/uart_tx.sv
// Burst UART transmitter: sends bytes_to_tx back-to-back 8N1 frames (LSB first)
// per request, with a fixed clocks-per-bit divider.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for a request with a non-zero count
// START  | start bit (line low)
// DATA   | eight payload bits, LSB first
// PARITY | even parity over the payload (only with UART_TX_PARITY_EN)
// STOP   | stop bit; chains straight into the next START while frames remain
// DONE   | burst sent, line high until the request level drops
module uart_tx #(
  parameter int CLKS_PER_BIT = 2,
  parameter int COUNT_W      = 10
) (
  input  logic     clock,
  input  logic     reset_n,
  uart_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [COUNT_W-1:0] burst_q, burst_d;
  logic [7:0]         shift_q, shift_d;
  logic               line_q, line_d;
  logic               cnt_done;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign cnt_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Next-state logic: bit timing, bit index, burst count and payload capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    burst_d  = burst_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.tx_data_valid && (bus.bytes_to_tx != '0)) begin
          burst_d  = bus.bytes_to_tx;
          shift_d  = bus.tx_data_byte;
`ifdef UART_TX_PARITY_EN
          parity_d = ^bus.tx_data_byte;
`endif
          cnt_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (cnt_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          burst_d = burst_q - COUNT_W'(1);
          // More frames pending: reload the payload now so the next start bit
          // follows the stop bit with no idle gap.
          if (burst_q != COUNT_W'(1)) begin
            shift_d  = bus.tx_data_byte;
`ifdef UART_TX_PARITY_EN
            parity_d = ^bus.tx_data_byte;
`endif
            state_d  = S_START;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!bus.tx_data_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line level follows the state being entered so the registered output
  // changes on the same edge as the state.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_d = parity_d;
`endif
      default:  line_d = 1'b1;
    endcase
  end

  // State, counters, payload and the registered serial line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      burst_q  <= '0;
      shift_q  <= '0;
      line_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      burst_q  <= burst_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.serial_data_out = line_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: bursts are queued into a scoreboard as expected bytes and
// a line monitor rebuilds each frame waveform and compares it sample by sample.
module tb_uart_tx;

  localparam int CPB     = 2;
  localparam int COUNT_W = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  logic [7:0] bb [8];

  uart_tx_if #(.COUNT_W(COUNT_W)) bus ();

  uart_tx #(.CLKS_PER_BIT(CPB), .COUNT_W(COUNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Ideal line level at sample k of a frame carrying byte b.
  function automatic logic exp_level(input logic [7:0] b, input int k);
    int j;
    j = k / CPB;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Monitor: detects start bits, captures a full frame and checks it.
  logic mon_cap = 1'b0;
  logic mon_have = 1'b0;
  logic mon_expect_start = 1'b0;
  int   mon_idx = 0;
  exp_t mon_cur;
  logic mon_samples [FRAME];

  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        mon_cap = 1'b0;
        mon_expect_start = 1'b0;
      end else begin
        if (mon_expect_start) begin
          mon_expect_start = 1'b0;
          chk("frame_gap", {31'd0, bus.serial_data_out}, 32'd0);
        end
        if (!mon_cap && bus.serial_data_out === 1'b0) begin
          mon_cap = 1'b1;
          mon_idx = 0;
          if (sb_q.size() == 0) begin
            mon_have = 1'b0;
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got start bit, want idle line (t=%0t)", $time);
          end else begin
            mon_have = 1'b1;
            mon_cur = sb_q.pop_front();
          end
        end
        if (mon_cap) begin
          mon_samples[mon_idx] = bus.serial_data_out;
          mon_idx++;
          if (mon_idx == FRAME) begin
            mon_cap = 1'b0;
            if (mon_have) begin
              int bad;
              int first;
              bad = 0;
              first = -1;
              for (int k = 0; k < FRAME; k++) begin
                if (mon_samples[k] !== exp_level(mon_cur.data, k)) begin
                  bad++;
                  if (first < 0) first = k;
                end
              end
              n_tests++;
              if (bad != 0) begin
                n_fail++;
                $display("FAIL frame: byte %h has %0d wrong samples, first at %0d got %b want %b",
                         mon_cur.data, bad, first, mon_samples[first], exp_level(mon_cur.data, first));
              end
              if (!mon_cur.last) mon_expect_start = 1'b1;
            end
          end
        end
      end
    end
  end

  // Issue one burst of n frames from bb[]; valid held for `hold` cycles after the sampling edge.
  task automatic burst(input int n, input int hold, input bit scramble);
    int   total;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = bb[k];
      e.last = (k == n - 1);
      sb_q.push_back(e);
    end
    bus.bytes_to_tx   = COUNT_W'(n);
    bus.tx_data_byte  = bb[0];
    bus.tx_data_valid = 1'b1;
    total = ((n * FRAME > hold) ? n * FRAME : hold) + 6;
    for (int c = 1; c <= total; c++) begin
      @(negedge clock);
      if (c == 1) chk("start_latency", {31'd0, bus.serial_data_out}, 32'd0);
      for (int k = 1; k < n; k++) begin
        if (c == (k - 1) * FRAME + FRAME / 2) bus.tx_data_byte = bb[k];
      end
      if (scramble && c == 3) bus.bytes_to_tx = COUNT_W'($urandom_range(0, 1023));
      if (c > hold) bus.tx_data_valid = 1'b0;
    end
    bus.tx_data_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("drain", sb_q.size(), 32'd0);
  endtask

  initial begin
    int bad;
    int n;
    int hold;
    exp_t e;

    reset_n = 1'b0;
    bus.tx_data_valid = 1'b0;
    bus.bytes_to_tx = '0;
    bus.tx_data_byte = '0;
    repeat (3) @(negedge clock);
    chk("reset_line", {31'd0, bus.serial_data_out}, 32'd1);
    reset_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (bus.serial_data_out !== 1'b1) bad++;
    end
    chk("idle_100", bad, 0);

    bb[0] = 8'hEE;
    burst(1, 0, 1'b0);

    bb[0] = 8'hEE; bb[1] = 8'h93; bb[2] = 8'hD7;
    burst(3, 60, 1'b0);

    bb[0] = 8'h5A; bb[1] = 8'h01;
    burst(2, 200, 1'b0);

    bus.bytes_to_tx = '0;
    bus.tx_data_byte = 8'hFF;
    bus.tx_data_valid = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (bus.serial_data_out !== 1'b1) bad++;
    end
    bus.tx_data_valid = 1'b0;
    chk("zero_count", bad, 0);

    bb[0] = 8'hB2;
    burst(1, 0, 1'b0);

    bb[0] = 8'h00; bb[1] = 8'hFF;
    burst(2, 0, 1'b1);

    // Reset in the middle of the second frame's data bits.
    bb[0] = 8'hA5; bb[1] = 8'h3C; bb[2] = 8'h77;
    for (int k = 0; k < 3; k++) begin
      e.data = bb[k];
      e.last = (k == 2);
      sb_q.push_back(e);
    end
    bus.bytes_to_tx = COUNT_W'(3);
    bus.tx_data_byte = bb[0];
    bus.tx_data_valid = 1'b1;
    for (int c = 1; c <= FRAME + 7; c++) begin
      @(negedge clock);
      if (c > 0) bus.tx_data_valid = 1'b0;
      if (c == FRAME / 2) bus.tx_data_byte = bb[1];
    end
    #1 reset_n = 1'b0;
    #1 chk("reset_async", {31'd0, bus.serial_data_out}, 32'd1);
    sb_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clock);
      if (bus.serial_data_out !== 1'b1) bad++;
    end
    chk("reset_quiet", bad, 0);
    chk("reset_queue", sb_q.size(), 32'd0);

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) bb[k] = 8'($urandom_range(0, 255));
      hold = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, n * FRAME + 40);
      burst(n, hold, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
